pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX pipeline register.
- Carries an opaque data payload and a control bundle through DEPTH cascaded stages, using a valid/ready handshake instead of a bare enable.
- Each stage has an optional skid slot, so full throughput is kept with a registered ready.
- Supports synchronous flush (bubble insertion), stall, an occupancy count and a saturating flush-event counter. Used between any two pipeline stages of the MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 128: payload width (e.g. pc_plus_4, read_data_1, read_data_2, immediate concatenated).
- CTRL_W, 16: control bundle width (RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, funct, reg indices, ...).
- DEPTH, 1: number of cascaded stages; legal range 1..4.
- SKID, 1: 1 = two-entry slot per stage with registered in_ready; 0 = single register per stage with combinational ready pass-through.
- FLUSH_DATA, 0: 1 = flush also zeroes payload registers; 0 = payload holds its value on flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload at the head of the last stage.
- out_ctrl  out  CTRL_W  control at the head of the last stage; 0 whenever out_valid=0.
- stall  in  1  freezes all state.
- flush  in  1  discards every held beat.
- occupancy  out  $clog2(2*DEPTH+1)  number of valid entries held, all stages.
- flush_cnt  out  16  saturating count of flushes that discarded at least one valid entry.

Behaviour:
Reset (rst=0, asynchronous)
- All valid and skid-valid bits 0; all data and ctrl registers 0; occupancy=0; flush_cnt=0.
- out_valid=0 and in_ready=0 while rst=0.
- First cycle after release: in_ready=1 (if stall=0).
- Reset mid-transfer drops all beats with no partial output.

Handshake
- Transfer when valid & ready are high at a rising edge.
- Ordering is strictly FIFO; a beat is never duplicated or dropped, except by flush.
- out_data and out_ctrl are held stable while out_valid=1 and out_ready=0.

Latency and throughput
- Accept at edge N: out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles of latency counted from in_valid.
- With out_ready held high, one beat per cycle is sustained for both SKID values.

SKID=1, per stage
- States: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
- EMPTY -> ONE on accept.
- ONE -> ONE on accept together with drain; ONE -> FULL on accept without drain; ONE -> EMPTY on drain without accept.
- FULL -> ONE on drain: the skid entry moves to main.
- Stage ready is registered as !skid_valid, gated by !stall.

SKID=0, per stage
- stage_ready = !valid | next_ready.
- This is a combinational chain to in_ready.

Stall
- stall=1: in_ready=0; the output transfer is masked (out_valid stays visible but no beat is consumed); all registers hold.
- Equivalent to legacy en=0.

Flush
- Synchronous; takes priority over stall and over any same-cycle input or output transfer.
- At the edge: all valid/skid bits cleared, all ctrl registers zeroed, payload zeroed only if FLUSH_DATA=1.
- A beat presented on in_* in the flush cycle is discarded.
- Next cycle: out_valid=0, occupancy=0.

flush_cnt
- Increments at a flush edge if occupancy>0 before that edge.
- Saturates at 16'hFFFF; cleared only by reset.

occupancy
- Registered; updated every edge by +accept -drain, or forced to 0 by flush.

Decomposition:
- Shared include file pipe_defs.vh holds:
  - the occupancy-width function;
  - localparams for stage state encodings EMPTY/ONE/FULL;
  - the MIPS control-bundle field offsets (so ID/EX packs ctrl identically everywhere).
- Sub-module pipe_skid_slot: one stage with the SKID param. It is instantiated DEPTH times in a generate loop; the top adds the occupancy adder, flush_cnt and the output ctrl masking.

Test Plan:
- Reset: hold rst=0 with in_valid=1 for 3 cycles, then release -> out_valid=0, occupancy=0, flush_cnt=0, in_ready=0 during reset; in_ready=1 one cycle after release.
- Streaming, DEPTH=2, SKID=1, out_ready=1: send data 1..8 (ctrl=16'h00A5) back-to-back -> first out_valid 2 cycles after first accept; 8 beats in order, one per cycle, in_ready never drops.
- Backpressure, DEPTH=1, SKID=1: out_ready=0, push 0x11 and 0x22 -> occupancy=2, in_ready=0; then out_ready=1 -> 0x11 then 0x22 emitted, occupancy 1 then 0.
- Flush with stall: occupancy=3, stall=1, flush=1, in_valid=1 with data 0x99 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, flush_cnt=1, 0x99 never emitted; a second flush with occupancy=0 leaves flush_cnt=1.
- Stall hold (legacy en=0): out_valid=1 with out_data=0xAABBCCDD, stall=1, out_ready=1, in_data=0xFFFFFFFF for 4 cycles -> out_data unchanged, nothing consumed, in_ready=0.
- SKID=0, DEPTH=3: toggle out_ready 1,0,1,0 with a continuous input stream -> no loss or duplication; in_ready follows the combinational ready chain in the same cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg_pkg                                           |
// | Description : Shared definitions for the valid/ready pipeline register:    |
// |               slot state encodings, occupancy width, MIPS ctrl layout.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pipe_stage_reg_pkg;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = c_ST_EMPTY,
        ST_ONE   = c_ST_ONE,
        ST_FULL  = c_ST_FULL
    } slot_state_e;

    // Field offsets inside the control bundle, shared by every MIPS stage boundary
    localparam int c_CTRL_REGDST    = 0;
    localparam int c_CTRL_ALUSRC    = 1;
    localparam int c_CTRL_MEMTOREG  = 2;
    localparam int c_CTRL_REGWRITE  = 3;
    localparam int c_CTRL_MEMREAD   = 4;
    localparam int c_CTRL_MEMWRITE  = 5;
    localparam int c_CTRL_BRANCH    = 6;
    localparam int c_CTRL_ALUOP_LSB = 7;
    localparam int c_CTRL_ALUOP_W   = 2;
    localparam int c_CTRL_FUNCT_LSB = 9;
    localparam int c_CTRL_FUNCT_W   = 6;
    localparam int c_CTRL_USED_W    = 15;

    // Each stage holds at most two entries, so 2*depth+1 distinct counts
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    function automatic logic [15:0] pack_mips_ctrl(
        input logic       reg_dst,
        input logic       alu_src,
        input logic       mem_to_reg,
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_write,
        input logic       branch,
        input logic [1:0] alu_op,
        input logic [5:0] funct
    );
        logic [15:0] v;
        v = '0;
        v[c_CTRL_REGDST]   = reg_dst;
        v[c_CTRL_ALUSRC]   = alu_src;
        v[c_CTRL_MEMTOREG] = mem_to_reg;
        v[c_CTRL_REGWRITE] = reg_write;
        v[c_CTRL_MEMREAD]  = mem_read;
        v[c_CTRL_MEMWRITE] = mem_write;
        v[c_CTRL_BRANCH]   = branch;
        v[c_CTRL_ALUOP_LSB +: c_CTRL_ALUOP_W] = alu_op;
        v[c_CTRL_FUNCT_LSB +: c_CTRL_FUNCT_W] = funct;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_skid_slot                                               |
// | Description : One pipeline stage: two-entry skid slot (SKID=1) or single   |
// |               register with combinational ready pass-through (SKID=0).     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_skid_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 16,
    parameter int SKID       = 1,
    parameter int FLUSH_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    slot_state_e       r_state_q;
    slot_state_e       w_state_d;
    logic [DATA_W-1:0] r_main_data_q;
    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] r_main_ctrl_q;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] r_skid_data_q;
    logic [DATA_W-1:0] w_skid_data_d;
    logic [CTRL_W-1:0] r_skid_ctrl_q;
    logic [CTRL_W-1:0] w_skid_ctrl_d;
    logic              w_accept;
    logic              w_drain;

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on the local skid flop, breaking the ready chain
            assign in_ready = !stall && (r_state_q != ST_FULL);
        end else begin : g_pass
            assign in_ready = !stall && ((r_state_q == ST_EMPTY) || out_ready);
        end
    endgenerate

    assign out_valid = (r_state_q != ST_EMPTY);
    assign out_data  = r_main_data_q;
    assign out_ctrl  = r_main_ctrl_q;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready && !stall;

    always_comb begin
        w_state_d     = r_state_q;
        w_main_data_d = r_main_data_q;
        w_main_ctrl_d = r_main_ctrl_q;
        w_skid_data_d = r_skid_data_q;
        w_skid_ctrl_d = r_skid_ctrl_q;

        if (flush) begin
            w_state_d     = ST_EMPTY;
            w_main_ctrl_d = '0;
            w_skid_ctrl_d = '0;
            if (FLUSH_DATA != 0) begin
                w_main_data_d = '0;
                w_skid_data_d = '0;
            end
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_d     = ST_ONE;
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_main_data_d = in_data;
                        w_main_ctrl_d = in_ctrl;
                    end else if (w_accept) begin
                        w_state_d     = ST_FULL;
                        w_skid_data_d = in_data;
                        w_skid_ctrl_d = in_ctrl;
                    end else if (w_drain) begin
                        w_state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_d     = ST_ONE;
                        w_main_data_d = r_skid_data_q;
                        w_main_ctrl_d = r_skid_ctrl_q;
                    end
                end
                default: begin
                    w_state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= ST_EMPTY;
            r_main_data_q <= '0;
            r_main_ctrl_q <= '0;
            r_skid_data_q <= '0;
            r_skid_ctrl_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_main_data_q <= w_main_data_d;
            r_main_ctrl_q <= w_main_ctrl_d;
            r_skid_data_q <= w_skid_data_d;
            r_skid_ctrl_q <= w_skid_ctrl_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : DEPTH cascaded valid/ready pipeline stages with flush,       |
// |               stall, occupancy count and saturating flush-event counter.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 16,
    parameter int DEPTH      = 1,
    parameter int SKID       = 1,
    parameter int FLUSH_DATA = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [CTRL_W-1:0]                in_ctrl,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [CTRL_W-1:0]                out_ctrl,
    input  logic                             stall,
    input  logic                             flush,
    output logic [$clog2(2*DEPTH+1)-1:0]     occupancy,
    output logic [15:0]                      flush_cnt
);

    localparam int c_OCC_W = occ_width(DEPTH);

    logic [DEPTH:0]       w_valid;
    logic [DEPTH:0]       w_ready;
    logic [DATA_W-1:0]    w_data [DEPTH+1];
    logic [CTRL_W-1:0]    w_ctrl [DEPTH+1];
    logic                 w_accept;
    logic                 w_drain;
    logic [c_OCC_W-1:0]   r_occ_q;
    logic [c_OCC_W-1:0]   w_occ_d;
    logic [15:0]          r_flush_cnt_q;
    logic [15:0]          w_flush_cnt_d;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign w_ctrl[0]      = in_ctrl;
    assign w_ready[DEPTH] = out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            pipe_skid_slot #(
                .DATA_W     (DATA_W),
                .CTRL_W     (CTRL_W),
                .SKID       (SKID),
                .FLUSH_DATA (FLUSH_DATA)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .stall     (stall),
                .flush     (flush),
                .in_valid  (w_valid[gi]),
                .in_ready  (w_ready[gi]),
                .in_data   (w_data[gi]),
                .in_ctrl   (w_ctrl[gi]),
                .out_valid (w_valid[gi+1]),
                .out_ready (w_ready[gi+1]),
                .out_data  (w_data[gi+1]),
                .out_ctrl  (w_ctrl[gi+1])
            );
        end
    endgenerate

    // Hold in_ready low for the whole reset window, not just until the first edge
    assign in_ready  = w_ready[0] && rst;
    assign out_valid = w_valid[DEPTH];
    assign out_data  = w_data[DEPTH];
    assign out_ctrl  = w_valid[DEPTH] ? w_ctrl[DEPTH] : '0;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready && !stall;

    always_comb begin
        w_occ_d       = r_occ_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (flush) begin
            w_occ_d = '0;
            if ((r_occ_q != '0) && (r_flush_cnt_q != 16'hFFFF)) begin
                w_flush_cnt_d = r_flush_cnt_q + 16'd1;
            end
        end else begin
            w_occ_d = r_occ_q
                    + {{(c_OCC_W-1){1'b0}}, w_accept}
                    - {{(c_OCC_W-1){1'b0}}, w_drain};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ_q       <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_occ_q       <= w_occ_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign occupancy = r_occ_q;
    assign flush_cnt = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Self-checking bench; three pipe_stage_reg configurations     |
// |               against a queue-based transfer model.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [31:0] in_data_a   [3];
    logic [15:0] in_ctrl_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [31:0] out_data_a  [3];
    logic [15:0] out_ctrl_a  [3];
    logic        stall_a     [3];
    logic        flush_a     [3];
    logic [2:0]  occ_a       [3];
    logic [15:0] fcnt_a      [3];

    // instance 0: DEPTH=2 SKID=1, instance 1: DEPTH=1 SKID=1, instance 2: DEPTH=3 SKID=0
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int P_DEPTH = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
            localparam int P_SKID  = (g == 2) ? 0 : 1;
            localparam int P_OW    = $clog2(2 * P_DEPTH + 1);
            logic [P_OW-1:0] occ_w;
            pipe_stage_reg #(
                .DATA_W(32), .CTRL_W(16), .DEPTH(P_DEPTH), .SKID(P_SKID), .FLUSH_DATA(0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid_a[g]),
                .in_ready  (in_ready_a[g]),
                .in_data   (in_data_a[g]),
                .in_ctrl   (in_ctrl_a[g]),
                .out_valid (out_valid_a[g]),
                .out_ready (out_ready_a[g]),
                .out_data  (out_data_a[g]),
                .out_ctrl  (out_ctrl_a[g]),
                .stall     (stall_a[g]),
                .flush     (flush_a[g]),
                .occupancy (occ_w),
                .flush_cnt (fcnt_a[g])
            );
            assign occ_a[g] = 3'(occ_w);
        end
    endgenerate

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats in flight, in order, plus flush-event counters
    logic [31:0] m_qd [$];
    logic [15:0] m_qc [$];
    int          m_fcnt [3];

    logic        s_ready, s_ov, s_acc, s_drain, s_front_v;
    logic [31:0] s_od, s_front_d;
    logic [15:0] s_oc, s_front_c;
    int          s_occ, s_fc, s_pre_size, s_exp_fc;

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = '0;
            in_ctrl_a[k]   = '0;
            out_ready_a[k] = 1'b0;
            stall_a[k]     = 1'b0;
            flush_a[k]     = 1'b0;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic tick(input int k);
        #1;
        s_ready    = in_ready_a[k];
        s_ov       = out_valid_a[k];
        s_od       = out_data_a[k];
        s_oc       = out_ctrl_a[k];
        s_occ      = int'(occ_a[k]);
        s_fc       = int'(fcnt_a[k]);
        s_pre_size = m_qd.size();
        s_exp_fc   = m_fcnt[k];
        s_front_v  = (m_qd.size() > 0);
        s_front_d  = '0;
        s_front_c  = '0;
        if (s_front_v) begin
            s_front_d = m_qd[0];
            s_front_c = m_qc[0];
        end
        s_acc   = 1'b0;
        s_drain = 1'b0;
        if (flush_a[k]) begin
            if (m_qd.size() > 0 && m_fcnt[k] < 65535) m_fcnt[k]++;
            m_qd.delete();
            m_qc.delete();
        end else begin
            s_drain = s_ov && out_ready_a[k] && !stall_a[k];
            s_acc   = in_valid_a[k] && s_ready;
            if (s_drain && m_qd.size() > 0) begin
                void'(m_qd.pop_front());
                void'(m_qc.pop_front());
            end
            if (s_acc) begin
                m_qd.push_back(in_data_a[k]);
                m_qc.push_back(in_ctrl_a[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k] = 1'b1;
            in_data_a[k]  = $urandom;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (out_valid_a[k] !== 1'b0 || in_ready_a[k] !== 1'b0 || occ_a[k] !== 3'd0 || fcnt_a[k] !== 16'd0) begin
                    n_errors++;
                    $display("FAIL reset_state[%0d]: got ov=%b ir=%b occ=%0d fc=%0d expected 0 0 0 0",
                             k, out_valid_a[k], in_ready_a[k], occ_a[k], fcnt_a[k]);
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) in_valid_a[k] = 1'b0;
        rst = 1'b1;
        m_qd.delete();
        m_qc.delete();
        for (int k = 0; k < 3; k++) m_fcnt[k] = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready_a[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL ready_after_reset[%0d]: got %b expected 1", k, in_ready_a[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        int cyc, first_acc, first_ov, first_dr, last_dr, n_dr;
        logic [31:0] next_val;
        first_acc = -1; first_ov = -1; first_dr = -1; last_dr = -1; n_dr = 0;
        next_val = 32'd1;
        out_ready_a[0] = 1'b1;
        for (cyc = 0; cyc < 40 && n_dr < 8; cyc++) begin
            in_valid_a[0] = (next_val <= 32'd8);
            in_data_a[0]  = next_val;
            in_ctrl_a[0]  = 16'h00A5;
            tick(0);
            if (in_valid_a[0]) begin
                n_checks++;
                if (s_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stream_ready: got %b expected 1 at beat %0d", s_ready, next_val);
                end
            end
            if (s_acc) begin
                if (first_acc < 0) first_acc = cyc;
                next_val++;
            end
            if (s_ov && first_ov < 0) first_ov = cyc;
            if (s_drain) begin
                n_checks++;
                if (s_od !== s_front_d || s_oc !== 16'h00A5) begin
                    n_errors++;
                    $display("FAIL stream_data: got %0h/%0h expected %0h/00a5", s_od, s_oc, s_front_d);
                end
                if (first_dr < 0) first_dr = cyc;
                last_dr = cyc;
                n_dr++;
            end
        end
        in_valid_a[0] = 1'b0;
        n_checks++;
        if (n_dr != 8 || (last_dr - first_dr) != 7) begin
            n_errors++;
            $display("FAIL stream_rate: got %0d beats over %0d cycles expected 8 over 7", n_dr, last_dr - first_dr);
        end
        n_checks++;
        if ((first_ov - first_acc) != depth_of(0)) begin
            n_errors++;
            $display("FAIL stream_latency: got %0d expected %0d", first_ov - first_acc, depth_of(0));
        end
        out_ready_a[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4];
        int          exp_occ [4];
        exp_d   = '{32'h11, 32'h11, 32'h22, 32'h0};
        exp_occ = '{2, 2, 1, 0};
        out_ready_a[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_a[1] = 1'b1;
            in_data_a[1]  = (i == 0) ? 32'h11 : 32'h22;
            in_ctrl_a[1]  = 16'h0100 + 16'(i);
            tick(1);
            n_checks++;
            if (s_acc !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_push[%0d]: got ready %b expected 1", i, s_ready);
            end
        end
        in_valid_a[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_ready_a[1] = (i > 0);
            tick(1);
            n_checks++;
            if (s_occ != exp_occ[i] || (i < 3 && (s_ov !== 1'b1 || s_od !== exp_d[i])) || (i == 3 && s_ov !== 1'b0)) begin
                n_errors++;
                $display("FAIL bp_drain[%0d]: got occ=%0d ov=%b d=%0h expected occ=%0d d=%0h",
                         i, s_occ, s_ov, s_od, exp_occ[i], exp_d[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (s_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_full_ready: got %b expected 0", s_ready);
                end
            end
        end
        out_ready_a[1] = 1'b0;
    endtask

    task automatic test_flush_stall();
        logic got;
        int   exp_fc;
        logic seen_ov;
        out_ready_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[0] = 1'b1;
            in_data_a[0]  = 32'h31 + 32'(i);
            in_ctrl_a[0]  = 16'h0F00 | 16'(i);
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick(0);
                got = s_acc;
            end
            n_checks++;
            if (!got) begin
                n_errors++;
                $display("FAIL flush_fill[%0d]: got no accept expected accept within 10 cycles", i);
            end
        end
        in_valid_a[0] = 1'b0;
        tick(0);
        n_checks++;
        if (s_occ != 3) begin
            n_errors++;
            $display("FAIL flush_pre_occ: got %0d expected 3", s_occ);
        end
        exp_fc = m_fcnt[0] + 1;
        stall_a[0] = 1'b1; flush_a[0] = 1'b1;
        in_valid_a[0] = 1'b1; in_data_a[0] = 32'h99; in_ctrl_a[0] = 16'h0099;
        tick(0);
        n_checks++;
        if (out_valid_a[0] !== 1'b0 || occ_a[0] !== 3'd0 || out_ctrl_a[0] !== 16'h0 || int'(fcnt_a[0]) != exp_fc || m_fcnt[0] != exp_fc) begin
            n_errors++;
            $display("FAIL flush_post: got ov=%b occ=%0d ctrl=%0h fc=%0d expected 0 0 0 %0d",
                     out_valid_a[0], occ_a[0], out_ctrl_a[0], fcnt_a[0], exp_fc);
        end
        stall_a[0] = 1'b0; in_valid_a[0] = 1'b0;
        tick(0);
        flush_a[0] = 1'b0;
        n_checks++;
        if (int'(fcnt_a[0]) != exp_fc) begin
            n_errors++;
            $display("FAIL flush_empty_cnt: got %0d expected %0d", fcnt_a[0], exp_fc);
        end
        out_ready_a[0] = 1'b1;
        seen_ov = 1'b0;
        repeat (6) begin
            tick(0);
            seen_ov = seen_ov | s_ov;
        end
        n_checks++;
        if (seen_ov !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_discard: got out_valid=1 expected 0 after flush");
        end
        out_ready_a[0] = 1'b0;
    endtask

    task automatic test_stall_hold();
        out_ready_a[1] = 1'b0;
        in_valid_a[1] = 1'b1; in_data_a[1] = 32'hAABBCCDD; in_ctrl_a[1] = 16'h1234;
        tick(1);
        n_checks++;
        if (s_acc !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_push: got ready %b expected 1", s_ready);
        end
        stall_a[1] = 1'b1; out_ready_a[1] = 1'b1; in_data_a[1] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if (s_ov !== 1'b1 || s_od !== 32'hAABBCCDD || s_oc !== 16'h1234 || s_ready !== 1'b0 || s_occ != 1) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got ov=%b d=%0h c=%0h ir=%b occ=%0d expected 1 aabbccdd 1234 0 1",
                         i, s_ov, s_od, s_oc, s_ready, s_occ);
            end
        end
        stall_a[1] = 1'b0; in_valid_a[1] = 1'b0;
        tick(1);
        n_checks++;
        if (s_drain !== 1'b1 || s_od !== 32'hAABBCCDD) begin
            n_errors++;
            $display("FAIL stall_release: got drain=%b d=%0h expected 1 aabbccdd", s_drain, s_od);
        end
        tick(1);
        out_ready_a[1] = 1'b0;
    endtask

    task automatic test_skid0_chain();
        logic [31:0] nxt;
        int          n_acc, n_dr;
        logic        exp_ready;
        nxt = 32'h500; n_acc = 0; n_dr = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid_a[2]  = 1'b1;
            in_data_a[2]   = nxt;
            in_ctrl_a[2]   = nxt[15:0] ^ 16'h5A5A;
            out_ready_a[2] = (i % 2 == 0);
            tick(2);
            exp_ready = (s_pre_size < depth_of(2)) || out_ready_a[2];
            n_checks++;
            if (s_ready !== exp_ready) begin
                n_errors++;
                $display("FAIL chain_ready[%0d]: got %b expected %b (held=%0d)", i, s_ready, exp_ready, s_pre_size);
            end
            if (s_ov) begin
                n_checks++;
                if (!s_front_v || s_od !== s_front_d || s_oc !== s_front_c) begin
                    n_errors++;
                    $display("FAIL chain_data[%0d]: got %0h/%0h expected %0h/%0h", i, s_od, s_oc, s_front_d, s_front_c);
                end
            end
            if (s_acc) begin nxt++; n_acc++; end
            if (s_drain) n_dr++;
        end
        in_valid_a[2] = 1'b0; out_ready_a[2] = 1'b1;
        for (int t = 0; t < 20 && m_qd.size() > 0; t++) begin
            tick(2);
            if (s_drain) begin
                n_dr++;
                n_checks++;
                if (s_od !== s_front_d) begin
                    n_errors++;
                    $display("FAIL chain_tail: got %0h expected %0h", s_od, s_front_d);
                end
            end
        end
        tick(2);
        n_checks++;
        if (n_dr != n_acc || s_ov !== 1'b0 || s_occ != 0) begin
            n_errors++;
            $display("FAIL chain_count: got %0d out ov=%b occ=%0d expected %0d out 0 0", n_dr, s_ov, s_occ, n_acc);
        end
        out_ready_a[2] = 1'b0;
    endtask

    task automatic test_random();
        int n_dr;
        for (int k = 0; k < 3; k++) begin
            n_dr = 0;
            in_valid_a[k] = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (!in_valid_a[k] || s_acc || flush_a[k]) begin
                    in_valid_a[k] = ($urandom_range(0, 9) < 7);
                    in_data_a[k]  = $urandom;
                    in_ctrl_a[k]  = 16'($urandom);
                end
                out_ready_a[k] = ($urandom_range(0, 9) < 6);
                stall_a[k]     = ($urandom_range(0, 9) == 0);
                flush_a[k]     = ($urandom_range(0, 39) == 0);
                tick(k);
                if (s_drain) n_dr++;
                n_checks++;
                if (s_ov ? (!s_front_v || s_od !== s_front_d || s_oc !== s_front_c) : (s_oc !== 16'h0)) begin
                    n_errors++;
                    $display("FAIL rand_out[%0d/%0d]: got ov=%b %0h/%0h expected %0h/%0h (held=%0d)",
                             k, i, s_ov, s_od, s_oc, s_front_d, s_front_c, s_pre_size);
                end
                n_checks++;
                if (s_occ != s_pre_size || s_fc != s_exp_fc) begin
                    n_errors++;
                    $display("FAIL rand_count[%0d/%0d]: got occ=%0d fc=%0d expected %0d %0d",
                             k, i, s_occ, s_fc, s_pre_size, s_exp_fc);
                end
                if (stall_a[k] || k == 2) begin
                    n_checks++;
                    if (s_ready !== (!stall_a[k] && (k != 2 || s_pre_size < depth_of(2) || out_ready_a[k]))) begin
                        n_errors++;
                        $display("FAIL rand_ready[%0d/%0d]: got %b with stall=%b held=%0d", k, i, s_ready, stall_a[k], s_pre_size);
                    end
                end
            end
            n_checks++;
            if (n_dr == 0) begin
                n_errors++;
                $display("FAIL rand_progress[%0d]: got 0 beats expected some", k);
            end
            in_valid_a[k] = 1'b0; stall_a[k] = 1'b0; out_ready_a[k] = 1'b0;
            flush_a[k] = 1'b1;
            tick(k);
            flush_a[k] = 1'b0;
            n_checks++;
            if (out_valid_a[k] !== 1'b0 || int'(fcnt_a[k]) != m_fcnt[k]) begin
                n_errors++;
                $display("FAIL rand_final[%0d]: got ov=%b fc=%0d expected 0 %0d", k, out_valid_a[k], fcnt_a[k], m_fcnt[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_stall();
        test_stall_hold();
        test_skid0_chain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
